ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative 16-bit unsigned multiply/divide unit in the EX stage, beside the ALU.
//  Operands come from ID/EX Reg_Data_1/Reg_Data_2 after EX forwarding.
//  Holds the instruction in EX via Stall, which drives ~Enable on IF/ID and ID/EX
//  and CLR on EX/MEM, until the result is ready. Writes a HI/LO result pair.
// PARAMETERS
//  WIDTH   16  operand width; product/remainder width is 2*WIDTH / WIDTH
// PORTS
//  clk           in   1        rising-edge clock
//  Reset_N       in   1        asynchronous, active-low reset
//  Start         in   1        EX instruction is MUL/DIV (level, held while stalled)
//  Op            in   1        0 = MUL (A*B), 1 = DIV (A/B, A%B)
//  Operand_A     in   WIDTH    forwarded Rs value
//  Operand_B     in   WIDTH    forwarded Rt value
//  Flush         in   1        abort in-flight op (branch/jump flush of EX)
//  Stall         out  1        freeze upstream stages, bubble EX/MEM
//  Busy          out  1        FSM in RUN
//  Done          out  1        1-cycle pulse: Result_* updated this cycle
//  Result_Lo     out  WIDTH    MUL: product[15:0]; DIV: quotient
//  Result_Hi     out  WIDTH    MUL: product[31:16]; DIV: remainder
//  Div_By_Zero   out  1        sticky until the next accepted op; last DIV had B==0
// BEHAVIOUR
//  Reset (Reset_N=0, any time, mid-op included): state=IDLE. Stall, Busy, Done,
//   Div_By_Zero=0. Result_Lo/Hi=0. Counter and working regs=0.
//  FSM states: IDLE, RUN, DONE.
//  - IDLE: Start & ~Flush -> latch A, B and Op; clear Div_By_Zero. Then:
//     DIV with B==0 -> DONE; otherwise -> RUN with count=WIDTH-1.
//     Start ignored if Flush=1 in the same cycle.
//  - RUN: one radix-2 step per cycle.
//     MUL: shift-add; DIV: restoring, one quotient bit per cycle.
//     count==0 -> DONE; otherwise count-1. Flush -> IDLE; results untouched.
//  - DONE: Done=1 for exactly this cycle, with Result_Lo/Hi already valid.
//     Always -> IDLE. Start is ignored here: it still belongs to the completing
//     instruction, which advances this cycle.
//  Stall = (IDLE & Start & ~Flush) | RUN  (combinational). Deasserted in DONE.
//  Busy = RUN. Done is registered (state==DONE).
//  Latency: Start seen in IDLE at cycle N -> RUN during N+1..N+WIDTH -> Done at N+WIDTH+1.
//   Div-by-zero: Done at N+1.
//  Results register only on entry to DONE; held until the next completion.
//   Aborted ops never change them.
//  Div by zero: Result_Lo = all ones, Result_Hi = A, Div_By_Zero = 1.
//  Arithmetic is unsigned. The product is exact in 2*WIDTH bits; no overflow flag.
//  Back-to-back ops: a new Start in the IDLE cycle after DONE begins immediately.
//   Minimum spacing is WIDTH+2 cycles.
//  Operands sampled once at accept; later changes on Operand_A/B are ignored.
// TESTING
//  MUL 300*250 (0x012C*0x00FA), Start at N -> Stall N..N+16, Done at N+17,
//   Hi=0x0001, Lo=0x24F8.
//  DIV 1000/7 -> Done at N+17, Lo=0x008E, Hi=0x0006, Div_By_Zero=0.
//  DIV 0x1234/0 -> Done at N+1, Lo=0xFFFF, Hi=0x1234, Div_By_Zero=1.
//   Cleared by the next accepted op.
//  MUL 0xFFFF*0xFFFF then DIV 0xFFFF/0x0001 back-to-back:
//   first Hi=0xFFFE, Lo=0x0001; second Lo=0xFFFF, Hi=0.
//   Second Start accepted the cycle after the first Done.
//  Flush at N+5 during MUL -> IDLE at N+6, Stall/Busy=0, no Done,
//   prior Result_Lo/Hi unchanged.
//  Reset_N low at N+8 mid-DIV (async, between edges) -> all outputs 0 immediately.
//   A fresh op after release completes normally.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply/divide unit for the EX stage: shift-add MUL and
// restoring DIV, one bit per cycle, stalling the pipe until the HI/LO pair is ready.
module ex_muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             Reset_N,
  input  logic             Start,
  input  logic             Op,
  input  logic [WIDTH-1:0] Operand_A,
  input  logic [WIDTH-1:0] Operand_B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result_Lo,
  output logic [WIDTH-1:0] Result_Hi,
  output logic             Div_By_Zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  // MUL: hi = partial product, lo = multiplier shifting out / product low.
  // DIV: hi = partial remainder, lo = dividend shifting out / quotient in.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub, div_hi, div_lo;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign accept = (state_q == S_IDLE) && Start && !Flush;

  // Shift-add step: conditional add into the upper half, then shift the pair right.
  assign mul_sum = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, b_q});
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

  // Restoring step; the subtraction fits in WIDTH bits whenever it is taken.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, b_q});
  assign div_sub   = div_shift[WIDTH-1:0] - b_q;
  assign div_hi    = div_ge ? div_sub : div_shift[WIDTH-1:0];
  assign div_lo    = {lo_q[WIDTH-2:0], div_ge};

  assign step_hi = op_q ? div_hi : mul_hi;
  assign step_lo = op_q ? div_lo : mul_lo;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = Op;
          b_d   = Operand_B;
          hi_d  = '0;
          lo_d  = Operand_A;
          cnt_d = CW'(WIDTH - 1);
          dbz_d = 1'b0;
          if (Op && (Operand_B == '0)) begin
            state_d  = S_DONE;
            res_lo_d = '1;
            res_hi_d = Operand_A;
            dbz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d = step_hi;
          lo_d = step_lo;
          if (cnt_q == '0) begin
            // Results land on the DONE edge so they are valid while Done is high.
            state_d  = S_DONE;
            res_hi_d = step_hi;
            res_lo_d = step_lo;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  assign Stall       = accept || (state_q == S_RUN);
  assign Busy        = (state_q == S_RUN);
  assign Done        = (state_q == S_DONE);
  assign Result_Lo   = res_lo_q;
  assign Result_Hi   = res_hi_q;
  assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO/flag pushed at issue,
// popped and compared when Done fires; latency and stall timing checked inline.
module tb_ex_muldiv_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic Reset_N = 1'b0;
  logic Start = 1'b0;
  logic Op = 1'b0;
  logic Flush = 1'b0;
  logic [W-1:0] Operand_A = '0;
  logic [W-1:0] Operand_B = '0;
  logic Stall, Busy, Done, Div_By_Zero;
  logic [W-1:0] Result_Lo, Result_Hi;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .Reset_N(Reset_N), .Start(Start), .Op(Op),
    .Operand_A(Operand_A), .Operand_B(Operand_B), .Flush(Flush),
    .Stall(Stall), .Busy(Busy), .Done(Done),
    .Result_Lo(Result_Lo), .Result_Hi(Result_Hi), .Div_By_Zero(Div_By_Zero)
  );

  function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    if (!op) begin
      e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.dbz = 1'b0;
    end else if (b == '0) begin
      e.lo = '1; e.hi = a; e.dbz = 1'b1;
    end else begin
      e.lo = a / b; e.hi = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge in the cycle the op is presented; returns at the negedge
  // of the Done cycle with Start still held (as the pipeline would).
  task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_lat);
    exp_t e;
    int k;
    bit seen;
    sb.push_back(model(op, a, b));
    Op = op; Operand_A = a; Operand_B = b; Start = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL stall_accept: got %b want 1", Stall); end
    k = 0; seen = 0;
    while (k < 40 && !seen) begin
      @(negedge clk); k++;
      if (Done === 1'b1) seen = 1;
      else begin
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL stall_hold: cyc %0d got %b want 1", k, Stall); end
        if (k == 1) begin
          checks++;
          if (Busy !== 1'b1 || Div_By_Zero !== 1'b0) begin
            errors++; $display("FAIL run_entry: busy=%b dbz=%b want busy=1 dbz=0", Busy, Div_By_Zero);
          end
        end
        Operand_A = W'($urandom); Operand_B = W'($urandom);
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL done_timeout: no Done within 40 cycles");
      if (sb.size() > 0) last_e = sb.pop_front();
    end else begin
      if (k != exp_lat) begin errors++; $display("FAIL latency: got %0d want %0d", k, exp_lat); end
      checks++;
      if (Stall !== 1'b0 || Busy !== 1'b0) begin
        errors++; $display("FAIL done_stall: stall=%b busy=%b want 0 0", Stall, Busy);
      end
      e = sb.pop_front();
      last_e = e;
      checks++;
      if (Result_Lo !== e.lo) begin errors++; $display("FAIL result_lo: got %h want %h", Result_Lo, e.lo); end
      checks++;
      if (Result_Hi !== e.hi) begin errors++; $display("FAIL result_hi: got %h want %h", Result_Hi, e.hi); end
      checks++;
      if (Div_By_Zero !== e.dbz) begin errors++; $display("FAIL div_by_zero: got %b want %b", Div_By_Zero, e.dbz); end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({Stall, Busy, Done, Div_By_Zero, Result_Lo, Result_Hi} !== '0) begin
      errors++; $display("FAIL reset_state: st=%b bz=%b dn=%b dz=%b lo=%h hi=%h want all 0",
                         Stall, Busy, Done, Div_By_Zero, Result_Lo, Result_Hi);
    end
    Reset_N = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    do_op(1'b0, 16'd300, 16'd250, 17);
    checks++;
    if (Result_Hi !== 16'h0001 || Result_Lo !== 16'h24F8) begin
      errors++; $display("FAIL mul_const: got %h_%h want 0001_24f8", Result_Hi, Result_Lo);
    end
    Start = 1'b0;
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Result_Lo !== 16'h24F8) begin
      errors++; $display("FAIL done_pulse: done=%b lo=%h want 0 24f8", Done, Result_Lo);
    end
  endtask

  task automatic test_div();
    do_op(1'b1, 16'd1000, 16'd7, 17);
    checks++;
    if (Result_Lo !== 16'h008E || Result_Hi !== 16'h0006) begin
      errors++; $display("FAIL div_const: got lo=%h hi=%h want 008e 0006", Result_Lo, Result_Hi);
    end
    Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    do_op(1'b1, 16'h1234, 16'h0000, 1);
    Start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (Div_By_Zero !== 1'b1 || Busy !== 1'b0 || Result_Lo !== 16'hFFFF) begin
      errors++; $display("FAIL dbz_sticky: dbz=%b busy=%b lo=%h want 1 0 ffff", Div_By_Zero, Busy, Result_Lo);
    end
    do_op(1'b0, 16'd3, 16'd5, 17);
    Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 17);
    checks++;
    if (Result_Hi !== 16'hFFFE || Result_Lo !== 16'h0001) begin
      errors++; $display("FAIL b2b_mul: got %h_%h want fffe_0001", Result_Hi, Result_Lo);
    end
    @(negedge clk);
    checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: done=%b busy=%b want 0 0", Done, Busy);
    end
    do_op(1'b1, 16'hFFFF, 16'h0001, 17);
    checks++;
    if (Result_Lo !== 16'hFFFF || Result_Hi !== 16'h0000) begin
      errors++; $display("FAIL b2b_div: got lo=%h hi=%h want ffff 0000", Result_Lo, Result_Hi);
    end
    Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit done_seen;
    Op = 1'b0; Operand_A = 16'd300; Operand_B = 16'd250; Start = 1'b1;
    repeat (5) @(negedge clk);
    Start = 1'b0; Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    checks++;
    if (Busy !== 1'b0 || Stall !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL flush_idle: busy=%b stall=%b done=%b want 0 0 0", Busy, Stall, Done);
    end
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (Done === 1'b1) done_seen = 1;
    end
    checks++;
    if (done_seen) begin errors++; $display("FAIL flush_no_done: got Done after flush want none"); end
    checks++;
    if (Result_Lo !== last_e.lo || Result_Hi !== last_e.hi) begin
      errors++; $display("FAIL flush_results: got %h_%h want %h_%h", Result_Hi, Result_Lo, last_e.hi, last_e.lo);
    end
    // Start together with Flush in IDLE must be ignored.
    Op = 1'b1; Operand_A = 16'h5555; Operand_B = 16'h0000; Start = 1'b1; Flush = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall: got %b want 0", Stall); end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Div_By_Zero !== 1'b0) begin
      errors++; $display("FAIL flush_start_ignored: busy=%b done=%b dbz=%b want 0 0 0", Busy, Done, Div_By_Zero);
    end
    Start = 1'b0; Flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    Op = 1'b1; Operand_A = 16'd1000; Operand_B = 16'd7; Start = 1'b1;
    repeat (8) @(negedge clk);
    #2;
    Start = 1'b0; Reset_N = 1'b0;
    #1;
    checks++;
    if ({Stall, Busy, Done, Div_By_Zero, Result_Lo, Result_Hi} !== '0) begin
      errors++; $display("FAIL async_reset: st=%b bz=%b dn=%b dz=%b lo=%h hi=%h want all 0",
                         Stall, Busy, Done, Div_By_Zero, Result_Lo, Result_Hi);
    end
    @(negedge clk);
    Reset_N = 1'b1;
    @(negedge clk);
    do_op(1'b1, 16'hBEEF, 16'h0012, 17);
    Start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      if (i == 4) b = '0;
      else if (i[0]) b = W'($urandom_range(1, 15));
      else b = W'($urandom);
      do_op(op, a, b, (op && b == '0) ? 1 : 17);
      Start = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
